ps2_rx_controller: RTL and testbench

Sequences reception of PS/2 keyboard frames in the system clock domain. It synchronizes the raw `ps2_clk`/`ps2_data` pins, frames the 11-bit PS/2 packet with a state machine, and checks start, parity and stop bits. It folds the E0 (extended) and F0 (break) prefixes into a single key event, then queues events in a small FIFO. The FIFO drains to the piece-animator logic through a valid/ready handshake.

---
 rtl/ps2_evt_if.sv | 20 ++
 rtl/ps2_rx_controller.sv | 171 +++++++++++++++++
 tb/tb_ps2_rx_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_evt_if.sv
// ps2_evt_if
// Key-event handshake between the PS/2 receiver and its consumer.
//   evt_valid : head event present (driven by the receiver)
//   evt_ready : consumer accepts the head event
//   evt_code  : 8-bit scan code of the head event
//   evt_ext   : head event was E0-prefixed
//   evt_break : head event was F0-prefixed (key release)
// Modports: master = event producer, slave = event consumer.
interface ps2_evt_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (output evt_valid, output evt_code, output evt_ext,
                  output evt_break, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_ext,
                  input evt_break, output evt_ready);
endinterface

// File: rtl/ps2_rx_controller.sv
// ps2_rx_controller
// Receives PS/2 keyboard frames in the clk domain: synchronizes the raw pins,
// frames start/8 data/parity/stop, checks odd parity and the stop bit, folds
// E0/F0 prefixes into one key event and queues events in a small FIFO.
//   clk, reset      : system clock, asynchronous active-high reset
//   ps2_clk/ps2_data: raw keyboard pins (asynchronous)
//   evt             : event handshake (master side), head of the FIFO
//   frame_err       : 1-cycle pulse on a bad or timed-out frame
//   overflow        : 1-cycle pulse when an event is dropped on a full FIFO
module ps2_rx_controller #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      ps2_clk,
  input  logic      ps2_data,
  ps2_evt_if.master evt,
  output logic      frame_err,
  output logic      overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           state_q, state_d;
  logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_hist_q, clk_hist_d;
  logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic             frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [9:0]       mem_q [FIFO_DEPTH];  // {ext, break, code}

  logic       fall, push, push_ok, pop, full, valid;
  logic [9:0] push_data;

  assign fall  = clk_hist_q & ~clk_s2_q;
  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop   = valid & evt.evt_ready;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    push        = 1'b0;
    push_data   = {ext_pend_q, brk_pend_q, shift_q};
    clk_s1_d    = ps2_clk;
    clk_s2_d    = clk_s1_q;
    clk_hist_d  = clk_s2_q;
    dat_s1_d    = ps2_data;
    dat_s2_d    = dat_s1_q;
    to_d        = (state_q == S_IDLE || fall) ? '0 : to_q + TO_W'(1);

    if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          // A high "start" bit is line noise; simply keep waiting.
          if (!dat_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_q && ((^shift_q) ^ par_q)) begin
            if (shift_q == 8'hE0)      ext_pend_d = 1'b1;
            else if (shift_q == 8'hF0) brk_pend_d = 1'b1;
            else begin
              push       = 1'b1;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && to_q == TO_LAST) begin
      // Keyboard stalled mid-frame: drop whatever was collected.
      state_d     = S_IDLE;
      bitcnt_d    = 3'd0;
      shift_d     = 8'h00;
      frame_err_d = 1'b1;
    end

    if (frame_err_d) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end

    // A full FIFO can still take a push when the head leaves this cycle.
    push_ok    = push & (~full | pop);
    overflow_d = push & ~push_ok;
    wr_d       = push_ok ? wr_q + PTR_W'(1) : wr_q;
    rd_d       = pop ? rd_q + PTR_W'(1) : rd_q;
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_hist_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      to_q        <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_hist_q  <= clk_hist_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_q        <= to_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      if (push_ok) mem_q[wr_q] <= push_data;
    end
  end

  assign evt.evt_valid = valid;
  assign evt.evt_code  = mem_q[rd_q][7:0];
  assign evt.evt_break = mem_q[rd_q][8];
  assign evt.evt_ext   = mem_q[rd_q][9];
  assign frame_err     = frame_err_q;
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_ps2_rx_controller.sv
// tb_ps2_rx_controller
// Drives PS/2 frames bit by bit and compares received events, error pulses
// and overflow pulses with a queue-based reference of the key-event rules.
module tb_ps2_rx_controller;
  localparam int TO    = 200;
  localparam int DEPTH = 4;
  localparam int H     = 15;   // ps2_clk half period in clk cycles

  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic frame_err, overflow;

  ps2_evt_if evt_if();

  ps2_rx_controller #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt(evt_if), .frame_err(frame_err), .overflow(overflow));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int fe_cnt = 0, ov_cnt = 0, fe_wide = 0, exp_fe = 0, exp_ov = 0;
  bit fe_prev = 1'b0, m_ext = 1'b0, m_brk = 1'b0;
  logic [9:0] got_q[$], exp_q[$], m_fifo[$];

  // Observe the handshake and pulses mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        got_q.push_back({evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code});
        $display("[%0t] event code=%02h ext=%0d break=%0d", $time,
                 evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break);
      end
      if (frame_err) fe_cnt++;
      if (frame_err && fe_prev) fe_wide++;
      if (overflow) ov_cnt++;
      fe_prev = frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: prefixes accumulate, a plain code emits one event, errors clear.
  task automatic model_frame(input logic [7:0] code, input bit good);
    if (!good) begin
      exp_fe++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (code == 8'hE0) m_ext = 1'b1;
    else if (code == 8'hF0) m_brk = 1'b1;
    else begin
      if (m_fifo.size() == DEPTH) exp_ov++;
      else m_fifo.push_back({m_ext, m_brk, code});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic m_drain();
    while (m_fifo.size() > 0) exp_q.push_back(m_fifo.pop_front());
  endtask

  task automatic send_bits(input logic [7:0] code, input bit bad_par,
                           input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits = {1'b1 ^ bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clk(H);
      ps2_clk = 1'b0;
      wait_clk(H);
      ps2_clk = 1'b1;
    end
    wait_clk(H);
    ps2_data = 1'b1;
  endtask

  task automatic tx(input logic [7:0] code, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    $display("[%0t] tx code=%02h bad_par=%0d bad_stop=%0d", $time, code, bad_par, bad_stop);
    send_bits(code, bad_par, bad_stop, 11);
    model_frame(code, !(bad_par || bad_stop));
    wait_clk(10);
    if (evt_if.evt_ready) m_drain();
  endtask

  task automatic abort_frame(input int nbits);
    $display("[%0t] tx partial frame, %0d bits then stall", $time, nbits);
    send_bits(8'($urandom_range(0, 255)), 1'b0, 1'b0, nbits);
    wait_clk(TO + 40);
    exp_fe++;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic checkpoint(input string tag);
    int n;
    check({tag, "_frame_err"}, fe_cnt, exp_fe);
    check({tag, "_overflow"}, ov_cnt, exp_ov);
    check({tag, "_nevents"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_event"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, evt_if.evt_valid, 0);
    check({tag, "_code"}, evt_if.evt_code, 0);
    check({tag, "_ext"}, evt_if.evt_ext, 0);
    check({tag, "_break"}, evt_if.evt_break, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    logic [7:0] ovf_codes [5];
    ovf_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    evt_if.evt_ready = 1'b1;
    wait_clk(5);
    check_outputs_zero("reset");
    reset = 1'b0;
    wait_clk(5);

    tx(8'h1C);
    checkpoint("single_1c");

    tx(8'hF0); tx(8'h1C);
    checkpoint("break_1c");
    tx(8'hE0); tx(8'hF0); tx(8'h75);
    tx(8'h75);
    checkpoint("ext_break_75");

    tx(8'h1C, 1'b1, 1'b0);
    tx(8'h1C, 1'b0, 1'b1);
    tx(8'h1B);
    checkpoint("bad_frames");

    abort_frame(5);
    tx(8'h23);
    checkpoint("timeout");
    tx(8'hE0);
    abort_frame(5);
    tx(8'h23);
    checkpoint("timeout_ext");

    evt_if.evt_ready = 1'b0;
    foreach (ovf_codes[i]) tx(ovf_codes[i]);
    check("ovf_count", ov_cnt, exp_ov);
    check("ovf_valid", evt_if.evt_valid, 1);
    check("ovf_head_stable", evt_if.evt_code, 8'h15);
    evt_if.evt_ready = 1'b1;
    wait_clk(10);
    m_drain();
    checkpoint("ovf_drain");
    check("ovf_empty", evt_if.evt_valid, 0);

    evt_if.evt_ready = 1'b0;
    tx(8'h33); tx(8'h42);
    send_bits(8'h5A, 1'b0, 1'b0, 6);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_outputs_zero("async_reset");
    m_fifo.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    wait_clk(5);
    reset = 1'b0;
    evt_if.evt_ready = 1'b1;
    wait_clk(5);
    tx(8'h1C);
    checkpoint("after_reset");

    for (int it = 0; it < 30; it++) begin
      logic [7:0] c;
      int r;
      c = 8'($urandom_range(0, 255));
      if (c == 8'hE0 || c == 8'hF0) c = 8'h2B;
      r = $urandom_range(0, 99);
      if (r < 30) tx(8'hE0);
      if ($urandom_range(0, 3) == 0) tx(8'hF0);
      if (r >= 85) abort_frame($urandom_range(1, 10));
      tx(c, $urandom_range(0, 9) == 0, 1'b0);
    end
    checkpoint("random");
    check("frame_err_width", fe_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
